// File: rtl/wasm_value_stack_pkg.sv
// wasm_pkg: opcode and trap encodings shared by the operand stack and the
// rest of the WebAssembly core.
//   stack_op_e : 3-bit stack opcode issued by the decoder
//   trap_e     : 4-bit trap code, same convention as the core
package wasm_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_PUSH   = 3'd1,
      OP_DROP   = 3'd2,
      OP_EQZ32  = 3'd3,
      OP_EQZ64  = 3'd4,
      OP_DUP    = 3'd5,
      OP_SELECT = 3'd6,
      OP_RSVD   = 3'd7
   } stack_op_e;

   typedef enum logic [3:0] {
      TRAP_NONE      = 4'd0,
      TRAP_UNDERFLOW = 4'd1,
      TRAP_OVERFLOW  = 4'd2,
      TRAP_ILLEGAL   = 4'd3
   } trap_e;

endpackage

// File: rtl/wasm_value_stack_eqz_unit.sv
// wasm_eqz_unit: combinational zero test producing a WIDTH-bit 0/1 value.
// Also intended for reuse by the branch unit.
//   value   : operand
//   is64    : 1 tests the full operand, 0 tests only value[31:0]
//   is_zero : 1 (zero-extended) when the tested bits are all zero
module wasm_eqz_unit #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] value,
   input  logic             is64,
   output logic [WIDTH-1:0] is_zero
);

   logic zero;

   always_comb begin
      if (is64) zero = (value == '0);
      else      zero = (value[31:0] == 32'd0);
      is_zero = {{(WIDTH-1){1'b0}}, zero};
   end

endmodule

// File: rtl/wasm_value_stack.sv
// wasm_value_stack: operand stack for the WebAssembly core.
// Top-of-stack lives in top_q and is presented directly as result; entries
// below it live in mem_q, the entry just under the top at index count-2.
// Any trap is sticky until reset and freezes the stack.
// Optional feature macro: WASM_STACK_SELECT_EN (enables op 6 SELECT;
// otherwise op 6 traps as illegal).
//   clk, reset           : clock, synchronous active-high reset
//   op_valid/op_ready/op : one-cycle op handshake
//   push_data            : PUSH operand
//   result/result_empty  : top-of-stack (0 when empty), empty flag
//   count                : stored entries
//   trap                 : trap_e code
module wasm_value_stack
   import wasm_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] result,
   output logic             result_empty,
   output logic [PTR_W-1:0] count,
   output logic [3:0]       trap
);

   localparam int IDX_W = PTR_W - 1;
   localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] CNT_TWO  = PTR_W'(2);

   logic [WIDTH-1:0] top_q, top_d;
   logic [PTR_W-1:0] count_q, count_d;
   trap_e            trap_q, trap_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             mem_we;
   logic [IDX_W-1:0] idx_m1, idx_m2;
   logic             is_empty, is_full;
   stack_op_e        op_e;
   logic [WIDTH-1:0] eqz_out;

   assign op_e     = stack_op_e'(op);
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);
   // idx_m1: slot the old top moves into on a push; idx_m2: entry under top.
   assign idx_m1   = IDX_W'(count_q - CNT_ONE);
   assign idx_m2   = IDX_W'(count_q - CNT_TWO);

   wasm_eqz_unit #(.WIDTH(WIDTH)) u_eqz (
      .value   (top_q),
      .is64    (op_e == OP_EQZ64),
      .is_zero (eqz_out)
   );

`ifdef WASM_STACK_SELECT_EN
   logic [IDX_W-1:0] idx_m3;
   assign idx_m3 = IDX_W'(count_q - PTR_W'(3));
`endif

   always_comb begin
      top_d   = top_q;
      count_d = count_q;
      trap_d  = trap_q;
      mem_we  = 1'b0;
      if (op_valid && (trap_q == TRAP_NONE)) begin
         case (op_e)
            OP_NOP: ;
            OP_PUSH: begin
               if (is_full) trap_d = TRAP_OVERFLOW;
               else begin
                  // An empty stack has no live top to shift down.
                  mem_we  = !is_empty;
                  top_d   = push_data;
                  count_d = count_q + CNT_ONE;
               end
            end
            OP_DROP: begin
               if (is_empty) trap_d = TRAP_UNDERFLOW;
               else begin
                  top_d   = (count_q == CNT_ONE) ? '0 : mem_q[idx_m2];
                  count_d = count_q - CNT_ONE;
               end
            end
            OP_EQZ32: begin
               if (is_empty) trap_d = TRAP_UNDERFLOW;
               else          top_d  = eqz_out;
            end
            OP_EQZ64: begin
               if (WIDTH == 32)   trap_d = TRAP_ILLEGAL;
               else if (is_empty) trap_d = TRAP_UNDERFLOW;
               else               top_d  = eqz_out;
            end
            OP_DUP: begin
               if (is_empty)     trap_d = TRAP_UNDERFLOW;
               else if (is_full) trap_d = TRAP_OVERFLOW;
               else begin
                  mem_we  = 1'b1;
                  count_d = count_q + CNT_ONE;
               end
            end
`ifdef WASM_STACK_SELECT_EN
            OP_SELECT: begin
               if (count_q < PTR_W'(3)) trap_d = TRAP_UNDERFLOW;
               else begin
                  // cond = top, b = entry below, a = entry below b.
                  top_d   = (top_q[31:0] != 32'd0) ? mem_q[idx_m3] : mem_q[idx_m2];
                  count_d = count_q - CNT_TWO;
               end
            end
`endif
            default: trap_d = TRAP_ILLEGAL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         top_q   <= '0;
         count_q <= '0;
         trap_q  <= TRAP_NONE;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         trap_q  <= trap_d;
      end
   end

   // Storage is not reset; entries above count are never read.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem_q[idx_m1] <= top_q;
   end

   assign result       = top_q;
   assign result_empty = is_empty;
   assign count        = count_q;
   assign trap         = trap_q;
   assign op_ready     = (trap_q == TRAP_NONE);

endmodule

// File: doc/wasm_value_stack.md
Name: wasm_value_stack

Overview:
- Parametrised operand stack for the WebAssembly core; it replaces the core's fixed-width single-result register.
- Holds up to DEPTH values of WIDTH bits.
- Executes stack-local ops (push, drop, i32/i64 eqz, dup) issued by the core's decoder.
- Exposes top-of-stack as `result` with an empty flag and a 4-bit trap code matching the core's trap convention.

Parameters:
- WIDTH, 64, value width in bits; must be 32 or 64.
- DEPTH, 16, maximum number of stored entries; must be a power of two, ≥ 2.
- PTR_W, $clog2(DEPTH)+1, width of the entry counter (derived; do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- op_valid  input  1  op request this cycle
- op_ready  output  1  block accepts an op this cycle
- op  input  3  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 EQZ32, 4 EQZ64, 5 DUP, 6 SELECT (optional), 7 reserved
- push_data  input  WIDTH  value for PUSH
- result  output  WIDTH  current top-of-stack (0 when empty)
- result_empty  output  1  stack holds no entries
- count  output  PTR_W  number of stored entries
- trap  output  4  0 none, 1 underflow, 2 overflow, 3 illegal op

Behaviour:
- Clock and reset:
  - Single clock `clk`; `reset` is synchronous, active-high.
  - On reset: count=0, result=0, result_empty=1, trap=0, op_ready=1.
  - Reset mid-op discards the op; storage contents are don't-care.
- Handshake:
  - An op is accepted when op_valid && op_ready.
  - op_ready = (trap==0).
  - Each accepted op completes in one cycle; its effect is visible on result, count and result_empty the following cycle.
- Storage:
  - Top entry is held in register `top`; lower entries are in an array indexed by count-2.
  - result = top, registered.
- Ops:
  - PUSH: if count==DEPTH, set trap=2 and leave state unchanged. Otherwise shift top into the array, top←push_data, count+1.
  - DROP: if count==0, set trap=1. Otherwise top←array[count-2] (or 0 if count==1), count-1.
  - EQZ32: if count==0, set trap=1. Otherwise top←(top[31:0]==0) zero-extended to WIDTH; count unchanged.
  - EQZ64: if WIDTH==32, set trap=3. If count==0, set trap=1. Otherwise top←(top==0) zero-extended; count unchanged.
  - DUP: count==0 → trap=1; count==DEPTH → trap=2. Otherwise push a copy of top.
  - NOP: no effect.
  - Op 7, or SELECT when the feature is compiled out: trap=3.
- Trap:
  - A trap sets the code in the same cycle the offending op is accepted; the code is visible the next cycle.
  - Trap is sticky until reset; all further ops are refused (op_ready=0).
  - Storage is frozen while trapped.
- Boundaries:
  - Count wraps never; overflow is trapped instead.
  - Last DROP (count 1→0) gives result=0 and result_empty=1.
  - PUSH at count DEPTH-1 succeeds, giving count=DEPTH.
- Ops are never simultaneous; only one op is issued per cycle.

Optional Feature:
- Macro: WASM_STACK_SELECT_EN.
- Defined: op 6 SELECT pops cond (top), then b, then a, and pushes (cond[31:0]!=0 ? a : b).
  - Requires count≥3, else trap=1.
  - Net count change is -2; completes in one cycle.
- Undefined: op 6 sets trap=3. No three-entry read logic is synthesised.

Decomposition:
- Package `wasm_pkg` holds:
  - `stack_op_e` enum (3-bit opcodes above).
  - `trap_e` enum (4-bit: TRAP_NONE=0, TRAP_UNDERFLOW=1, TRAP_OVERFLOW=2, TRAP_ILLEGAL=3), shared with the core.
- One sub-module, `wasm_eqz_unit`:
  - Combinational, parametrised WIDTH.
  - Inputs: value, is64. Output: WIDTH-bit 0/1.
  - Reused later by the branch unit.

Test Plan:
- Reset, then PUSH 64'h0, then EQZ64 → after 2 accepted ops: result=1, result_empty=0, count=1, trap=0.
- PUSH 64'hFFFF_FFFF_0000_0000, then EQZ32 → result=1; repeat the sequence with EQZ64 → result=0.
- PUSH 16 values 1..16 at DEPTH=16 → count=16, result=16; a 17th PUSH → trap=2, op_ready=0, result stays 16.
- From an empty stack, DROP → trap=1, result_empty=1; assert reset → trap=0, op_ready=1.
- PUSH 5, DUP, DROP, DROP → result sequence 5, 5, 5, 0; final result_empty=1, count=0.
- With WASM_STACK_SELECT_EN: PUSH 7, PUSH 9, PUSH 0, SELECT → result=9, count=1. Without the macro: same sequence → trap=3.
